// File: rtl/mover_fsm_n_pkg.sv
// Shared definitions for the mover_fsm_n floor-mover controller.
//   state_t      : one-hot state encoding, also visible on the estado/prox_estado ports
//   width_of()   : max(1, clog2(n)), used to size the floor and timer registers
package mover_fsm_n_pkg;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_UP    = 5'b00010,
        S_DOWN  = 5'b00100,
        S_STOP  = 5'b01000,
        S_ERROR = 5'b10000
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int width_of(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mover_fsm_n_if.sv
// Command/status bundle between a controlling agent and mover_fsm_n.
//   go_up, go_down       : manual one-floor move requests
//   req_valid, req_floor : target-floor request strobe and floor number
//   req_ready            : controller idle and able to take a request
//   floor                : current floor
//   top_lim, bott_lim    : floor is at the top / bottom position
//   estado, prox_estado  : one-hot current / next state
//   busy                 : moving or dwelling
// Modports: master drives the commands, slave is the controller.
interface mover_fsm_n_if #(
    parameter int FW = 3
);
    logic          go_up;
    logic          go_down;
    logic          req_valid;
    logic [FW-1:0] req_floor;
    logic          req_ready;
    logic [FW-1:0] floor;
    logic          top_lim;
    logic          bott_lim;
    logic [4:0]    estado;
    logic [4:0]    prox_estado;
    logic          busy;

    modport master (
        output go_up, go_down, req_valid, req_floor,
        input  req_ready, floor, top_lim, bott_lim, estado, prox_estado, busy
    );

    modport slave (
        input  go_up, go_down, req_valid, req_floor,
        output req_ready, floor, top_lim, bott_lim, estado, prox_estado, busy
    );
endinterface

// File: rtl/mover_fsm_n_timer.sv
// fsm_timer: loadable down-counter with a done flag, shared between the
// per-floor travel time and the STOP dwell time.
//   CLK      : clock
//   halt     : asynchronous active-high reset (count cleared)
//   load     : load load_val this cycle (wins over en)
//   load_val : value to load; done rises load_val cycles later when en is held
//   en       : count down by one (saturates at zero)
//   done     : count has reached zero
module fsm_timer #(
    parameter int W = 2
) (
    input  logic         CLK,
    input  logic         halt,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);
    logic [W-1:0] count_reg;

    always_ff @(posedge CLK or posedge halt) begin
        if (halt) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);
endmodule

// File: rtl/mover_fsm_n.sv
// mover_fsm_n: one-hot controller that moves a carriage between N_FLOORS
// positions, one floor per TRAVEL_CYCLES clocks, then dwells DWELL_CYCLES in STOP.
//   CLK  : clock, all state changes on the rising edge
//   halt : asynchronous active-high reset; aborts any move, floor returns to 0
//   bus  : mover_fsm_n_if.slave, commands in and status out
module mover_fsm_n
    import mover_fsm_n_pkg::*;
#(
    parameter int N_FLOORS      = 8,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DWELL_CYCLES  = 3
) (
    input  logic         CLK,
    input  logic         halt,
    mover_fsm_n_if.slave bus
);
    localparam int FW = width_of(N_FLOORS);
    localparam int TW = width_of((TRAVEL_CYCLES > DWELL_CYCLES) ? TRAVEL_CYCLES : DWELL_CYCLES);
    localparam logic [FW-1:0] TOP_FLOOR  = FW'(N_FLOORS - 1);
    localparam logic [TW-1:0] TRAVEL_LD  = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DWELL_LD   = TW'(DWELL_CYCLES - 1);

    state_t        state_reg, state_next;
    logic [FW-1:0] floor_reg, floor_next;
    logic [FW-1:0] target_reg, target_next;
    logic          busy_reg, ready_reg;

    logic          tmr_load;
    logic [TW-1:0] tmr_load_val;
    logic          tmr_en;
    logic          tmr_done;

    logic          both_dirs;
    logic          at_top, at_bott;
    logic [FW:0]   req_wide;
    logic [FW-1:0] req_clamped;

    assign both_dirs = bus.go_up & bus.go_down;
    assign at_top    = (floor_reg == TOP_FLOOR);
    assign at_bott   = (floor_reg == '0);

    // Widened compare keeps the clamp meaningful when N_FLOORS is not a power of two.
    assign req_wide    = {1'b0, bus.req_floor};
    assign req_clamped = (req_wide > (FW + 1)'(N_FLOORS - 1)) ? TOP_FLOOR : bus.req_floor;

    fsm_timer #(.W(TW)) u_timer (
        .CLK      (CLK),
        .halt     (halt),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    always_comb begin
        state_next   = state_reg;
        floor_next   = floor_reg;
        target_next  = target_reg;
        tmr_load     = 1'b0;
        tmr_load_val = TRAVEL_LD;
        tmr_en       = 1'b0;

        unique case (state_reg)
            S_IDLE: begin
                if (both_dirs) begin
                    state_next = S_ERROR;
                end else if (bus.req_valid) begin
                    target_next = req_clamped;
                    tmr_load    = 1'b1;
                    if (req_clamped > floor_reg) begin
                        state_next = S_UP;
                    end else if (req_clamped < floor_reg) begin
                        state_next = S_DOWN;
                    end else begin
                        state_next   = S_STOP;
                        tmr_load_val = DWELL_LD;
                    end
                end else if (bus.go_up && !at_top) begin
                    target_next = floor_reg + 1'b1;
                    state_next  = S_UP;
                    tmr_load    = 1'b1;
                end else if (bus.go_down && !at_bott) begin
                    target_next = floor_reg - 1'b1;
                    state_next  = S_DOWN;
                    tmr_load    = 1'b1;
                end
            end

            S_UP, S_DOWN: begin
                if (both_dirs) begin
                    // Freeze where we are; the partial floor is abandoned.
                    state_next = S_ERROR;
                end else if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (state_reg == S_UP) begin
                        if (!at_top) floor_next = floor_reg + 1'b1;
                    end else begin
                        if (!at_bott) floor_next = floor_reg - 1'b1;
                    end
                    // Limit check is a backstop: target is always reachable.
                    if ((floor_next == target_reg) ||
                        ((state_reg == S_UP) && at_top) ||
                        ((state_reg == S_DOWN) && at_bott)) begin
                        state_next   = S_STOP;
                        tmr_load_val = DWELL_LD;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end

            S_STOP: begin
                if (tmr_done) begin
                    state_next = S_IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            S_ERROR: begin
                if (!bus.go_up && !bus.go_down) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge halt) begin
        if (halt) begin
            state_reg  <= S_IDLE;
            floor_reg  <= '0;
            target_reg <= '0;
            busy_reg   <= 1'b0;
            ready_reg  <= 1'b1;
        end else begin
            state_reg  <= state_next;
            floor_reg  <= floor_next;
            target_reg <= target_next;
            busy_reg   <= (state_next == S_UP) || (state_next == S_DOWN) || (state_next == S_STOP);
            ready_reg  <= (state_next == S_IDLE);
        end
    end

    assign bus.floor       = floor_reg;
    assign bus.top_lim     = at_top;
    assign bus.bott_lim    = at_bott;
    assign bus.estado      = state_reg;
    assign bus.prox_estado = state_next;
    assign bus.busy        = busy_reg;
    assign bus.req_ready   = ready_reg;
endmodule

// File: tb/tb_mover_fsm_n.sv
module tb_mover_fsm_n;
    localparam int N  = 8;
    localparam int TC = 4;
    localparam int DC = 3;
    localparam int FW = 3;

    localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_STOP = 3, M_ERR = 4;

    logic clk;
    logic halt;
    int   total = 0;
    int   bad   = 0;

    mover_fsm_n_if #(.FW(FW)) bus ();

    mover_fsm_n #(.N_FLOORS(N), .TRAVEL_CYCLES(TC), .DWELL_CYCLES(DC)) dut (
        .CLK  (clk),
        .halt (halt),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] onehot(input int mode);
        case (mode)
            M_IDLE:  return 5'b00001;
            M_UP:    return 5'b00010;
            M_DOWN:  return 5'b00100;
            M_STOP:  return 5'b01000;
            default: return 5'b10000;
        endcase
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    // Position during a move is derived from elapsed cycles in the current leg.
    int m_mode, m_floor, m_target, m_leg_floor, m_leg_cycles, m_dwell;
    int n_mode, n_floor, n_target, n_leg_floor, n_leg_cycles, n_dwell;

    initial begin
        logic s_up, s_dn, s_rv;
        int   s_rf, t, dir;
        m_mode = M_IDLE; m_floor = 0; m_target = 0;
        m_leg_floor = 0; m_leg_cycles = 0; m_dwell = 0;
        forever begin
            @(negedge clk);
            if (halt) begin
                m_mode = M_IDLE; m_floor = 0; m_target = 0;
                m_leg_floor = 0; m_leg_cycles = 0; m_dwell = 0;
            end
            s_up = bus.go_up; s_dn = bus.go_down; s_rv = bus.req_valid;
            s_rf = int'(bus.req_floor);

            chk("estado",    32'(bus.estado),    32'(onehot(m_mode)));
            chk("floor",     32'(bus.floor),     32'(m_floor));
            chk("top_lim",   32'(bus.top_lim),   32'(m_floor == N - 1));
            chk("bott_lim",  32'(bus.bott_lim),  32'(m_floor == 0));
            chk("busy",      32'(bus.busy),      32'(m_mode == M_UP || m_mode == M_DOWN || m_mode == M_STOP));
            chk("req_ready", 32'(bus.req_ready), 32'(m_mode == M_IDLE));

            n_mode = m_mode; n_floor = m_floor; n_target = m_target;
            n_leg_floor = m_leg_floor; n_leg_cycles = m_leg_cycles; n_dwell = m_dwell;
            case (m_mode)
                M_IDLE: begin
                    if (s_up && s_dn) n_mode = M_ERR;
                    else if (s_rv) begin
                        t = (s_rf > N - 1) ? N - 1 : s_rf;
                        n_target = t;
                        n_leg_floor = m_floor; n_leg_cycles = 0;
                        if (t > m_floor) n_mode = M_UP;
                        else if (t < m_floor) n_mode = M_DOWN;
                        else begin n_mode = M_STOP; n_dwell = DC; end
                    end else if (s_up && m_floor != N - 1) begin
                        n_target = m_floor + 1; n_mode = M_UP;
                        n_leg_floor = m_floor; n_leg_cycles = 0;
                    end else if (s_dn && m_floor != 0) begin
                        n_target = m_floor - 1; n_mode = M_DOWN;
                        n_leg_floor = m_floor; n_leg_cycles = 0;
                    end
                end
                M_UP, M_DOWN: begin
                    if (s_up && s_dn) n_mode = M_ERR;
                    else begin
                        dir = (m_mode == M_UP) ? 1 : -1;
                        n_leg_cycles = m_leg_cycles + 1;
                        n_floor = m_leg_floor + dir * (n_leg_cycles / TC);
                        if (n_floor == m_target) begin n_mode = M_STOP; n_dwell = DC; end
                    end
                end
                M_STOP: begin
                    n_dwell = m_dwell - 1;
                    if (n_dwell == 0) n_mode = M_IDLE;
                end
                default: begin
                    if (!s_up && !s_dn) n_mode = M_IDLE;
                end
            endcase
            chk("prox_estado", 32'(bus.prox_estado), 32'(onehot(n_mode)));

            @(posedge clk);
            if (!halt) begin
                m_mode = n_mode; m_floor = n_floor; m_target = n_target;
                m_leg_floor = n_leg_floor; m_leg_cycles = n_leg_cycles; m_dwell = n_dwell;
            end
        end
    end

    // ---------------- stimulus with literal anchor checks ----------------
    task automatic edge_chk();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int saved;
        halt = 1'b1;
        bus.go_up = 1'b0; bus.go_down = 1'b0; bus.req_valid = 1'b0; bus.req_floor = '0;

        // Reset held for two edges
        repeat (2) edge_chk();
        chk("rst_estado", 32'(bus.estado), 32'h01);
        chk("rst_floor", 32'(bus.floor), 32'h0);
        chk("rst_bott", 32'(bus.bott_lim), 32'h1);
        chk("rst_top", 32'(bus.top_lim), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_ready", 32'(bus.req_ready), 32'h1);
        #1 halt = 1'b0;
        edge_chk();

        // Request floor 3 from floor 0
        #1 bus.req_valid = 1'b1; bus.req_floor = 3'd3;
        edge_chk();
        chk("r3_up", 32'(bus.estado), 32'h02);
        #1 bus.req_valid = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            edge_chk();
            if (i == 3)  chk("r3_f0", 32'(bus.floor), 32'd0);
            if (i == 4)  chk("r3_f1", 32'(bus.floor), 32'd1);
            if (i == 8)  chk("r3_f2", 32'(bus.floor), 32'd2);
            if (i == 12) chk("r3_f3", 32'(bus.floor), 32'd3);
            if (i == 12) chk("r3_stop", 32'(bus.estado), 32'h08);
            if (i == 14) chk("r3_stop_last", 32'(bus.estado), 32'h08);
            if (i == 15) chk("r3_idle", 32'(bus.estado), 32'h01);
        end

        // Go to the top, then push go_up against the limit
        #1 bus.req_valid = 1'b1; bus.req_floor = 3'd7;
        edge_chk();
        #1 bus.req_valid = 1'b0;
        for (int i = 0; i < 100 && !(bus.estado == 5'b00001 && bus.floor == 3'd7); i++) edge_chk();
        chk("top_reached", 32'(bus.floor), 32'd7);
        #1 bus.go_up = 1'b1;
        repeat (5) edge_chk();
        chk("top_hold_estado", 32'(bus.estado), 32'h01);
        chk("top_hold_floor", 32'(bus.floor), 32'd7);
        chk("top_lim", 32'(bus.top_lim), 32'd1);
        #1 bus.go_up = 1'b0;

        // Both directions during DOWN
        #1 bus.req_valid = 1'b1; bus.req_floor = 3'd2;
        edge_chk();
        chk("dn_start", 32'(bus.estado), 32'h04);
        #1 bus.req_valid = 1'b0;
        repeat (5) edge_chk();
        chk("dn_floor6", 32'(bus.floor), 32'd6);
        #1 bus.go_up = 1'b1; bus.go_down = 1'b1;
        edge_chk();
        chk("err_estado", 32'(bus.estado), 32'h10);
        saved = int'(bus.floor);
        repeat (3) edge_chk();
        chk("err_frozen", 32'(bus.floor), 32'(saved));
        #1 bus.go_up = 1'b0; bus.go_down = 1'b0;
        edge_chk();
        chk("err_exit", 32'(bus.estado), 32'h01);

        // halt mid-UP, observed before the next edge
        #1 bus.req_valid = 1'b1; bus.req_floor = 3'd7;
        edge_chk();
        #1 bus.req_valid = 1'b0;
        repeat (3) edge_chk();
        #1 halt = 1'b1;
        #1;
        chk("halt_estado", 32'(bus.estado), 32'h01);
        chk("halt_floor", 32'(bus.floor), 32'd0);
        edge_chk();
        #1 halt = 1'b0;

        // Full run 0 -> 7: 28 travel cycles
        #1 bus.req_valid = 1'b1; bus.req_floor = 3'd7;
        edge_chk();
        #1 bus.req_valid = 1'b0;
        for (int i = 1; i <= 28; i++) begin
            edge_chk();
            if (i == 27) chk("run7_f6", 32'(bus.floor), 32'd6);
            if (i == 28) chk("run7_f7", 32'(bus.floor), 32'd7);
            if (i == 28) chk("run7_stop", 32'(bus.estado), 32'h08);
        end
        repeat (4) edge_chk();

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            edge_chk();
            #1;
            if (halt) halt = 1'b0;
            else if ($urandom_range(299) == 0) halt = 1'b1;
            bus.go_up     = ($urandom_range(9) == 0);
            bus.go_down   = ($urandom_range(9) == 0);
            bus.req_valid = ($urandom_range(3) == 0);
            bus.req_floor = FW'($urandom_range(N - 1));
        end
        #1;
        halt = 1'b0;
        bus.go_up = 1'b0; bus.go_down = 1'b0; bus.req_valid = 1'b0;
        repeat (40) edge_chk();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
